// File: rtl/led_fader_pkg.sv
// Shared types and constants for the LED fader.
package led_fader_pkg;

    // Per-channel operating mode, two bits per channel on the mode bus.
    typedef enum logic [1:0] {
        MODE_BREATHE = 2'd0,
        MODE_SAW     = 2'd1,
        MODE_FIXED   = 2'd2,
        MODE_OFF     = 2'd3
    } mode_t;

    // Direction of the breathing ramp.
    typedef enum logic {
        DirDown = 1'b0,
        DirUp   = 1'b1
    } dir_e;

endpackage

// File: rtl/led_fader_if.sv
// Control and output bundle of the LED fader.
interface led_fader_if #(
    parameter int unsigned N_CH  = 3,
    parameter int unsigned PWM_W = 8,
    parameter int unsigned SPD_W = 16
) ();

    logic                   i_en;
    logic                   i_sync;
    logic [2*N_CH-1:0]      i_mode;
    logic [SPD_W*N_CH-1:0]  i_speed;
    logic [PWM_W*N_CH-1:0]  i_level;
    logic [N_CH-1:0]        o_led;
    logic                   o_period;

    // Controller side: drives configuration, observes LEDs.
    modport master (
        output i_en, i_sync, i_mode, i_speed, i_level,
        input  o_led, o_period
    );

    // Fader side.
    modport slave (
        input  i_en, i_sync, i_mode, i_speed, i_level,
        output o_led, o_period
    );

endinterface

// File: rtl/led_fader_ch.sv
// One LED channel: step prescaler, level/direction generator, duty latch and PWM compare.
module led_fader_ch
    import led_fader_pkg::*;
#(
    parameter int unsigned PWM_W = 8,
    parameter int unsigned SPD_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             period_i,
    input  logic [PWM_W-1:0] pwm_cnt_i,
    input  mode_t            mode_i,
    input  logic [SPD_W-1:0] speed_i,
    input  logic [PWM_W-1:0] level_i,
    output logic             led_o
);

    localparam logic [PWM_W-1:0] LvlMax = '1;

    logic [SPD_W-1:0] div_q, div_d;
    logic [PWM_W-1:0] lvl_q, lvl_d;
    logic [PWM_W-1:0] duty_q, duty_d;
    dir_e             dir_q, dir_d;
    logic             led_q, led_d;
    logic             step;

    // Prescaler: '>=' so a speed drop below the running count steps at once.
    always_comb begin
        div_d = div_q;
        step  = 1'b0;
        if (sync_i) begin
            div_d = '0;
        end else if (en_i) begin
            if (speed_i == '0) begin
                div_d = '0;
            end else if (div_q >= speed_i - SPD_W'(1)) begin
                step  = 1'b1;
                div_d = '0;
            end else begin
                div_d = div_q + SPD_W'(1);
            end
        end
    end

    // Level and direction update per mode; turns skip the repeated endpoint.
    always_comb begin
        lvl_d = lvl_q;
        dir_d = dir_q;
        if (sync_i) begin
            lvl_d = '0;
            dir_d = DirUp;
        end else if (en_i) begin
            unique case (mode_i)
                MODE_BREATHE: begin
                    if (step) begin
                        if (dir_q == DirUp) begin
                            if (lvl_q == LvlMax) begin
                                lvl_d = LvlMax - PWM_W'(1);
                                dir_d = DirDown;
                            end else begin
                                lvl_d = lvl_q + PWM_W'(1);
                            end
                        end else begin
                            if (lvl_q == '0) begin
                                lvl_d = PWM_W'(1);
                                dir_d = DirUp;
                            end else begin
                                lvl_d = lvl_q - PWM_W'(1);
                            end
                        end
                    end
                end
                MODE_SAW: begin
                    if (step) begin
                        lvl_d = lvl_q + PWM_W'(1);
                    end
                end
                MODE_FIXED: lvl_d = level_i;
                MODE_OFF:   lvl_d = '0;
                default:    lvl_d = lvl_q;
            endcase
        end
    end

    // Duty only changes at the period boundary so a PWM period is never torn.
    always_comb begin
        duty_d = duty_q;
        if (sync_i) begin
            duty_d = '0;
        end else if (period_i) begin
            duty_d = lvl_q;
        end
    end

    // PWM compare, registered.
    always_comb begin
        led_d = en_i & (pwm_cnt_i < duty_q);
    end

    // Channel state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q  <= '0;
            lvl_q  <= '0;
            duty_q <= '0;
            dir_q  <= DirUp;
            led_q  <= 1'b0;
        end else begin
            div_q  <= div_d;
            lvl_q  <= lvl_d;
            duty_q <= duty_d;
            dir_q  <= dir_d;
            led_q  <= led_d;
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/led_fader.sv
// Multi-channel LED fader: shared PWM counter plus N_CH independent channels.
// Reset asserts asynchronously; its release is expected already aligned to i_clk.
module led_fader
    import led_fader_pkg::*;
#(
    parameter int unsigned N_CH  = 3,
    parameter int unsigned PWM_W = 8,
    parameter int unsigned SPD_W = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    led_fader_if.slave  bus
);

    localparam logic [PWM_W-1:0] PwmMax = '1;

    logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic             period;
    logic [N_CH-1:0]  led;

    // Shared PWM counter: sync restarts, disable freezes.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q;
        if (bus.i_sync) begin
            pwm_cnt_d = '0;
        end else if (bus.i_en) begin
            pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
        end
    end

    // PWM counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    // Last enabled cycle of each PWM period.
    always_comb begin
        period = bus.i_en & (pwm_cnt_q == PwmMax);
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        led_fader_ch #(
            .PWM_W (PWM_W),
            .SPD_W (SPD_W)
        ) u_ch (
            .clk_i     (i_clk),
            .rst_ni    (i_rst_n),
            .en_i      (bus.i_en),
            .sync_i    (bus.i_sync),
            .period_i  (period),
            .pwm_cnt_i (pwm_cnt_q),
            .mode_i    (mode_t'(bus.i_mode[2*k +: 2])),
            .speed_i   (bus.i_speed[SPD_W*k +: SPD_W]),
            .level_i   (bus.i_level[PWM_W*k +: PWM_W]),
            .led_o     (led[k])
        );
    end

    assign bus.o_led    = led;
    assign bus.o_period = period;

endmodule

// File: tb/tb_led_fader.sv
// Self-checking bench for led_fader: per-period duty scoreboard plus timing checks.
module tb_led_fader;
    import led_fader_pkg::*;

    logic clk;
    logic rst_n;

    led_fader_if #(.N_CH(3), .PWM_W(8), .SPD_W(16)) bus ();

    led_fader #(
        .N_CH  (3),
        .PWM_W (8),
        .SPD_W (16)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned exp_q[$];      // expected duties, ch0..ch2 per period
    int unsigned win_cnt[3];
    int unsigned skip;
    bit          mon_on = 1'b0;

    task automatic check_eq(string tag, int unsigned obs, int unsigned exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Triangle level after t breathe steps from 0 going up.
    function automatic int unsigned breathe_lvl(int unsigned t);
        int unsigned m = t % 510;
        return (m <= 255) ? m : 510 - m;
    endfunction

    // Accumulate LED high cycles; each o_period closes a window of one duty.
    task automatic sample();
        if (!mon_on) return;
        for (int k = 0; k < 3; k++) win_cnt[k] += 32'(bus.o_led[k]);
        if (bus.o_period) begin
            if (skip > 0) begin
                skip--;
            end else begin
                for (int k = 0; k < 3; k++) begin
                    if (exp_q.size() > 0)
                        check_eq($sformatf("duty ch%0d", k), win_cnt[k], exp_q.pop_front());
                end
            end
            for (int k = 0; k < 3; k++) win_cnt[k] = 0;
        end
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(negedge clk);
            sample();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_ch(int k, mode_t m, int unsigned spd, int unsigned lvl);
        bus.i_mode[2*k +: 2]   = m;
        bus.i_speed[16*k +: 16] = spd[15:0];
        bus.i_level[8*k +: 8]   = lvl[7:0];
    endtask

    // One-cycle sync; the first window after it is discarded.
    task automatic do_sync();
        mon_on     = 1'b0;
        bus.i_sync = 1'b1;
        step(1);
        bus.i_sync = 1'b0;
        skip       = 1;
        for (int k = 0; k < 3; k++) win_cnt[k] = 0;
        mon_on     = 1'b1;
    endtask

    task automatic drain(string tag);
        int unsigned budget = 3000;
        while (exp_q.size() > 0 && budget > 0) begin
            step(1);
            budget--;
        end
        check_eq(tag, exp_q.size(), 0);
        exp_q.delete();
        mon_on = 1'b0;
    endtask

    // Count cycles (current cycle = 1) until o_period, then check it is one cycle wide.
    task automatic measure_period(string tag, int unsigned exp_n);
        int unsigned n = 0;
        bit found = 1'b0;
        for (int i = 1; i <= 600 && !found; i++) begin
            @(negedge clk);
            if (bus.o_period) begin
                found = 1'b1;
                n = i;
            end
            @(posedge clk);
            #1;
        end
        check_eq(tag, n, exp_n);
        @(negedge clk);
        check_eq({tag, " width"}, 32'(bus.o_period), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b1;
        bus.i_en    = 1'b0;
        bus.i_sync  = 1'b0;
        bus.i_mode  = '0;
        bus.i_speed = '0;
        bus.i_level = '0;
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.i_en = 1'b1;
        @(negedge clk);
        check_eq("reset led", 32'(bus.o_led), 0);
        check_eq("reset period", 32'(bus.o_period), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        measure_period("period after reset", 256);

        // FIXED levels 64/0/255.
        set_ch(0, MODE_FIXED, 0, 64);
        set_ch(1, MODE_FIXED, 0, 0);
        set_ch(2, MODE_FIXED, 0, 255);
        do_sync();
        repeat (3) begin
            exp_q.push_back(64);
            exp_q.push_back(0);
            exp_q.push_back(255);
        end
        drain("fixed drained");

        // BREATHE speed 1, SAW speed 3, FIXED 100 turned into BREATHE hold; 50-cycle disable.
        set_ch(0, MODE_BREATHE, 1, 0);
        set_ch(1, MODE_SAW, 3, 0);
        set_ch(2, MODE_FIXED, 0, 100);
        do_sync();
        for (int n = 1; n <= 5; n++) begin
            exp_q.push_back(breathe_lvl(256 * n - 1));
            exp_q.push_back(((256 * n - 1) / 3) % 256);
            exp_q.push_back(100);
        end
        step(300);
        set_ch(2, MODE_BREATHE, 0, 0);
        step(100);
        bus.i_en = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check_eq("period while disabled", 32'(bus.o_period), 0);
            if (i > 0) check_eq("led while disabled", 32'(bus.o_led), 0);
            sample();
            @(posedge clk);
            #1;
        end
        bus.i_en = 1'b1;
        drain("breathe drained");

        // FIXED level 10 -> 200 mid-period; OFF channel ignores level.
        set_ch(0, MODE_FIXED, 0, 10);
        set_ch(1, MODE_FIXED, 0, 10);
        set_ch(2, MODE_OFF, 0, 10);
        do_sync();
        exp_q.push_back(10);
        exp_q.push_back(10);
        exp_q.push_back(0);
        repeat (2) begin
            exp_q.push_back(200);
            exp_q.push_back(200);
            exp_q.push_back(0);
        end
        step(356);
        set_ch(0, MODE_FIXED, 0, 200);
        set_ch(1, MODE_FIXED, 0, 200);
        set_ch(2, MODE_OFF, 0, 200);
        drain("level change drained");

        // Speed 1000 -> 2 with div_cnt at 500: steps on cycles 501,503,...
        // so lvl is 6 at the 512th cycle and 134 at the 768th.
        set_ch(0, MODE_BREATHE, 1000, 0);
        set_ch(1, MODE_OFF, 0, 0);
        set_ch(2, MODE_FIXED, 0, 0);
        do_sync();
        exp_q.push_back(0);   exp_q.push_back(0); exp_q.push_back(0);
        exp_q.push_back(6);   exp_q.push_back(0); exp_q.push_back(0);
        exp_q.push_back(134); exp_q.push_back(0); exp_q.push_back(0);
        step(500);
        set_ch(0, MODE_BREATHE, 2, 0);
        drain("speed drop drained");

        // Sync in a step cycle restarts the PWM phase.
        set_ch(0, MODE_BREATHE, 1, 0);
        step(37);
        do_sync();
        mon_on = 1'b0;
        measure_period("period after sync", 256);

        // Asynchronous reset mid-period.
        set_ch(0, MODE_FIXED, 0, 255);
        set_ch(1, MODE_FIXED, 0, 255);
        set_ch(2, MODE_FIXED, 0, 255);
        do_sync();
        mon_on = 1'b0;
        step(300);
        check_eq("led before reset", 32'(bus.o_led), 7);
        #1 rst_n = 1'b0;
        #1;
        check_eq("led async reset", 32'(bus.o_led), 0);
        check_eq("period async reset", 32'(bus.o_period), 0);
        @(posedge clk);
        #1;
        step(2);
        rst_n = 1'b1;
        measure_period("period after mid reset", 256);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/led_fader.md
LED_FADER -- requirements
Module: led_fader

Interface
REQ-001 Parameter N_CH, default 3: number of independent LED channels (1..16).
REQ-002 Parameter PWM_W, default 8: PWM counter and brightness width in bits.
REQ-003 Parameter SPD_W, default 16: step-prescaler width in bits.
REQ-004 i_clk  input  1: single clock; all state SHALL be in this domain.
REQ-005 i_rst_n  input  1: asynchronous, active-low reset.
REQ-006 i_en  input  1: global enable; low freezes all counters.
REQ-007 i_sync  input  1: synchronous phase restart of all channels.
REQ-008 i_mode  input  2*N_CH: per-channel mode, channel k at bits [2k+1:2k].
REQ-009 i_speed  input  SPD_W*N_CH: per-channel step period in enabled clock cycles; 0 means hold.
REQ-010 i_level  input  PWM_W*N_CH: per-channel brightness used in FIXED mode.
REQ-011 o_led  output  N_CH: registered PWM output, one bit per channel.
REQ-012 o_period  output  1: one-cycle pulse marking the last cycle of each PWM period.

Function
REQ-013 Shared pwm_cnt (PWM_W bits) SHALL increment on each i_en-high cycle and wrap from 2^PWM_W-1 to 0.
REQ-014 o_period SHALL be high in exactly the cycle where i_en=1 and pwm_cnt=2^PWM_W-1.
REQ-015 Per-channel div_cnt: when i_en=1 and speed!=0, div_cnt>=speed-1 SHALL produce a step pulse and load 0; otherwise div_cnt increments.
REQ-016 speed=0 SHALL hold div_cnt at 0 and generate no steps; a speed decrease below div_cnt SHALL step on the next enabled cycle.
REQ-017 Modes: 0 BREATHE, 1 SAW, 2 FIXED, 3 OFF.
REQ-018 BREATHE on step: dir up with lvl<max gives lvl+1; lvl=max gives lvl=max-1 and dir down; dir down with lvl>0 gives lvl-1; lvl=0 gives lvl=1 and dir up; no value SHALL repeat at turns.
REQ-019 SAW on step: lvl+1, wrapping max to 0; dir is unchanged.
REQ-020 FIXED: lvl SHALL follow i_level every enabled cycle; OFF: lvl SHALL be 0; steps are ignored in both modes.
REQ-021 A mode change SHALL take effect on the next cycle, continuing from the current lvl and dir.
REQ-022 Per-channel duty SHALL load from lvl only in o_period cycles, giving a glitch-free PWM update.
REQ-023 o_led[k] SHALL be registered as i_en & (pwm_cnt < duty[k]): one-cycle latency, duty 0 is always off, and max duty gives (2^PWM_W-1)/2^PWM_W on-time.
REQ-024 i_sync=1 SHALL clear pwm_cnt, all div_cnt, lvl and duty, and set dir up, taking priority over step, i_en and the o_period load.
REQ-025 With i_en=0, all state SHALL hold, o_led SHALL be 0 from the next cycle, and o_period SHALL be 0.

Reset
REQ-026 i_rst_n low SHALL immediately and asynchronously clear pwm_cnt, div_cnt, lvl, duty, o_led and o_period, and set dir up.
REQ-027 Deassertion of i_rst_n SHALL be synchronous to i_clk; the first enabled cycle SHALL see pwm_cnt=0.

Structure
REQ-028 Package led_fader_pkg SHALL hold the mode constants MODE_BREATHE, MODE_SAW, MODE_FIXED and MODE_OFF and the 2-bit mode type.
REQ-029 Sub-module led_fader_ch (prescaler, lvl/dir, duty, compare) SHALL be instantiated N_CH times by generate; pwm_cnt and o_period remain in the top level.

Verification (N_CH=3, PWM_W=8, SPD_W=16)
REQ-030 FIXED, i_level=64/0/255, i_en=1 -> o_led high for 64/0/255 of every 256 cycles.
REQ-031 BREATHE, speed=1 -> lvl sequence 0,1..255,254..0,1 with a 510-step triangle and no repeated 255 or 0.
REQ-032 speed=3 -> step every 3rd enabled cycle; speed=0 -> lvl constant for 1000 cycles; speed 1000 to 2 with div_cnt=500 -> step next cycle.
REQ-033 FIXED, i_level changed 10 to 200 mid-period -> current period has 10 high cycles, the next period has 200.
REQ-034 i_sync asserted in a step cycle -> all lvl=0 and pwm_cnt=0 next cycle; o_period 256 cycles after sync deasserts.
REQ-035 i_rst_n pulled low mid-period between clock edges -> o_led=0 without a clock edge; i_en low for 50 cycles -> lvl and pwm_cnt resume unchanged.
